ro_sample_sequencer: RTL and testbench

//  Control and collection stage for the ring-oscillator counter reconfigurable partition (rp).

---
 rtl/ro_seq_pkg.sv | 34 +++
 rtl/ro_bus_sync.sv | 40 ++++
 rtl/ro_sample_sequencer.sv | 238 +++++++++++++++++++++++
 tb/tb_ro_sample_sequencer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ro_seq_pkg.sv
// Shared types and constants for the ring-oscillator sample sequencer.
package ro_seq_pkg;

  // Bit of rp_reg_0 / rp_reg_1 that carries go (outbound) and done (inbound).
  localparam int GO_DONE_BIT = 31;
  // Width of the oscillator count and of the window field.
  localparam int COUNT_W     = 31;
  // Sum width: COUNT_W + 8 so up to 256 full-scale samples cannot overflow.
  localparam int SUM_W       = 39;
  // Number of stability re-checks before a capture is forced.
  localparam int CAP_TRIES   = 8;
  localparam int CAP_W       = 3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARM       = 3'd1,
    ST_RUN       = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_CAPTURE   = 3'd4,
    ST_ACCUM     = 3'd5,
    ST_DONE      = 3'd6
  } state_e;

  function automatic logic [COUNT_W-1:0] cnt_min(input logic [COUNT_W-1:0] a,
                                                 input logic [COUNT_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [COUNT_W-1:0] cnt_max(input logic [COUNT_W-1:0] a,
                                                 input logic [COUNT_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ro_bus_sync.sv
// N-bit two-flop synchronizer followed by one extra register stage; the
// stable flag reports that two consecutive synchronized words agree.
module ro_bus_sync #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] d,
  output logic [N-1:0] sync1,
  output logic         stable
);

  logic [N-1:0] meta_q, meta_d;
  logic [N-1:0] sync1_q, sync1_d;
  logic [N-1:0] sync2_q, sync2_d;

  // Next values of the three-deep pipeline.
  always_comb begin
    meta_d  = d;
    sync1_d = meta_q;
    sync2_d = sync1_q;
  end

  // Pipeline registers; cleared by the asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q  <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      meta_q  <= meta_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign sync1  = sync1_q;
  assign stable = (sync1_q == sync2_q);

endmodule

// File: rtl/ro_sample_sequencer.sv
// Sequencer for the ring-oscillator counter partition: arms the rp, starts a
// window, collects the synchronized count and keeps last/min/max/sum.
// Optional feature macro: RO_SEQ_WATCHDOG_EN (WAIT_DONE watchdog + err_timeout).
module ro_sample_sequencer
  import ro_seq_pkg::*;
#(
  parameter int BUS_WIDTH   = 32,
  parameter int NSAMP_W     = 8,
  parameter int ARM_CYCLES  = 4,
  parameter int WDOG_CYCLES = 2**24
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 cmd_start,
  input  logic [BUS_WIDTH-2:0] cmd_window,
  input  logic [NSAMP_W-1:0]   cmd_nsamp,
  output logic [BUS_WIDTH-1:0] rp_reg_0,
  input  logic [BUS_WIDTH-1:0] rp_reg_1,
  output logic                 rp_reset,
  output logic                 busy,
  output logic                 done,
  output logic                 err_timeout,
  output logic [NSAMP_W:0]     samples_done,
  output logic [COUNT_W-1:0]   last_count,
  output logic [COUNT_W-1:0]   min_count,
  output logic [COUNT_W-1:0]   max_count,
  output logic [SUM_W-1:0]     sum_count
);

  localparam int ARM_W = $clog2(ARM_CYCLES + 1);

  state_e                 state_q, state_d;
  logic [ARM_W-1:0]       arm_cnt_q, arm_cnt_d;
  logic [CAP_W-1:0]       cap_cnt_q, cap_cnt_d;
  logic [BUS_WIDTH-2:0]   window_q, window_d;
  logic [NSAMP_W-1:0]     nsamp_q, nsamp_d;
  logic [COUNT_W-1:0]     cnt_q, cnt_d;
  logic                   rp_reset_q, rp_reset_d;
  logic [BUS_WIDTH-1:0]   rp_reg_0_q, rp_reg_0_d;
  logic                   done_q, done_d;
  logic [NSAMP_W:0]       samples_q, samples_d;
  logic [COUNT_W-1:0]     last_q, last_d;
  logic [COUNT_W-1:0]     min_q, min_d;
  logic [COUNT_W-1:0]     max_q, max_d;
  logic [SUM_W-1:0]       sum_q, sum_d;

  logic [BUS_WIDTH-1:0]   sync1;
  logic                   stable;
  logic                   start_accept;
  logic                   wdog_fire;
  logic [NSAMP_W:0]       samples_inc;
  logic [NSAMP_W:0]       eff_nsamp;

  // reg_1 comes from the oscillator domain, so every bit is synchronized.
  ro_bus_sync #(.N(BUS_WIDTH)) u_sync (
    .clk    (Clk),
    .rst    (Reset_n),
    .d      (rp_reg_1),
    .sync1  (sync1),
    .stable (stable)
  );

  assign start_accept = cmd_start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign samples_inc  = samples_q + (NSAMP_W+1)'(1);
  // A request of 0 means the full 2**NSAMP_W samples.
  assign eff_nsamp    = (nsamp_q == '0) ? {1'b1, {NSAMP_W{1'b0}}} : {1'b0, nsamp_q};

`ifdef RO_SEQ_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

  logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
  logic              err_q, err_d;

  assign wdog_fire = (state_q == ST_WAIT_DONE) && !sync1[GO_DONE_BIT] &&
                     (wdog_cnt_q == WDOG_W'(WDOG_CYCLES - 1));

  // Watchdog counts only while waiting for done; error is sticky until restart.
  always_comb begin
    wdog_cnt_d = '0;
    err_d      = err_q;
    if (state_q == ST_WAIT_DONE) wdog_cnt_d = wdog_cnt_q + WDOG_W'(1);
    if (start_accept)            err_d      = 1'b0;
    if (wdog_fire)               err_d      = 1'b1;
  end

  // Watchdog registers.
  always_ff @(posedge Clk or posedge Reset_n) begin
    if (Reset_n) begin
      wdog_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      wdog_cnt_q <= wdog_cnt_d;
      err_q      <= err_d;
    end
  end

  assign err_timeout = err_q;
`else
  // Without the watchdog WAIT_DONE waits forever for the rp.
  logic unused_wdog;
  assign unused_wdog = (WDOG_CYCLES == 0);
  assign wdog_fire   = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // Next-state and datapath logic of the measurement FSM.
  always_comb begin
    state_d    = state_q;
    arm_cnt_d  = arm_cnt_q;
    cap_cnt_d  = cap_cnt_q;
    window_d   = window_q;
    nsamp_d    = nsamp_q;
    cnt_d      = cnt_q;
    rp_reset_d = rp_reset_q;
    rp_reg_0_d = rp_reg_0_q;
    done_d     = done_q;
    samples_d  = samples_q;
    last_d     = last_q;
    min_d      = min_q;
    max_d      = max_q;
    sum_d      = sum_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (cmd_start) begin
          window_d   = cmd_window;
          nsamp_d    = cmd_nsamp;
          samples_d  = '0;
          sum_d      = '0;
          min_d      = '1;
          max_d      = '0;
          done_d     = 1'b0;
          arm_cnt_d  = '0;
          rp_reset_d = 1'b1;
          rp_reg_0_d = '0;
          state_d    = ST_ARM;
        end
      end
      ST_ARM: begin
        if (arm_cnt_q == ARM_W'(ARM_CYCLES - 1)) begin
          rp_reset_d = 1'b0;
          rp_reg_0_d = {1'b1, window_q};
          state_d    = ST_RUN;
        end else begin
          arm_cnt_d = arm_cnt_q + ARM_W'(1);
        end
      end
      ST_RUN: begin
        state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (sync1[GO_DONE_BIT]) begin
          cap_cnt_d = '0;
          state_d   = ST_CAPTURE;
        end else if (wdog_fire) begin
          done_d     = 1'b1;
          rp_reset_d = 1'b1;
          state_d    = ST_DONE;
        end
      end
      ST_CAPTURE: begin
        // Accept once two consecutive words agree; give up waiting after
        // CAP_TRIES checks and take the newest word.
        if ((stable && sync1[GO_DONE_BIT]) || (cap_cnt_q == CAP_W'(CAP_TRIES - 1))) begin
          cnt_d   = sync1[COUNT_W-1:0];
          state_d = ST_ACCUM;
        end else begin
          cap_cnt_d = cap_cnt_q + CAP_W'(1);
        end
      end
      ST_ACCUM: begin
        last_d    = cnt_q;
        sum_d     = sum_q + SUM_W'(cnt_q);
        min_d     = cnt_min(min_q, cnt_q);
        max_d     = cnt_max(max_q, cnt_q);
        samples_d = samples_inc;
        rp_reset_d = 1'b1;
        if (samples_inc == eff_nsamp) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          arm_cnt_d  = '0;
          rp_reg_0_d = '0;
          state_d    = ST_ARM;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM and datapath registers; reset parks the rp and clears accumulators.
  always_ff @(posedge Clk or posedge Reset_n) begin
    if (Reset_n) begin
      state_q    <= ST_IDLE;
      arm_cnt_q  <= '0;
      cap_cnt_q  <= '0;
      window_q   <= '0;
      nsamp_q    <= '0;
      cnt_q      <= '0;
      rp_reset_q <= 1'b1;
      rp_reg_0_q <= '0;
      done_q     <= 1'b0;
      samples_q  <= '0;
      last_q     <= '0;
      min_q      <= '1;
      max_q      <= '0;
      sum_q      <= '0;
    end else begin
      state_q    <= state_d;
      arm_cnt_q  <= arm_cnt_d;
      cap_cnt_q  <= cap_cnt_d;
      window_q   <= window_d;
      nsamp_q    <= nsamp_d;
      cnt_q      <= cnt_d;
      rp_reset_q <= rp_reset_d;
      rp_reg_0_q <= rp_reg_0_d;
      done_q     <= done_d;
      samples_q  <= samples_d;
      last_q     <= last_d;
      min_q      <= min_d;
      max_q      <= max_d;
      sum_q      <= sum_d;
    end
  end

  assign busy         = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done         = done_q;
  assign rp_reset     = rp_reset_q;
  assign rp_reg_0     = rp_reg_0_q;
  assign samples_done = samples_q;
  assign last_count   = last_q;
  assign min_count    = min_q;
  assign max_count    = max_q;
  assign sum_count    = sum_q;

endmodule

// File: tb/tb_ro_sample_sequencer.sv
// Scoreboard bench for ro_sample_sequencer with a behavioural rp on an
// unrelated oscillator clock. Build with RO_SEQ_WATCHDOG_EN to cover the watchdog.
module tb_ro_sample_sequencer;

  logic        Clk = 1'b0;
  logic        osc_clk = 1'b0;
  logic        Reset_n = 1'b1;
  logic        cmd_start = 1'b0;
  logic [30:0] cmd_window = '0;
  logic [7:0]  cmd_nsamp = '0;
  logic [31:0] rp_reg_0;
  logic [31:0] rp_reg_1;
  logic        rp_reset, busy, done, err_timeout;
  logic [8:0]  samples_done;
  logic [30:0] last_count, min_count, max_count;
  logic [38:0] sum_count;

  ro_sample_sequencer #(
    .BUS_WIDTH(32), .NSAMP_W(8), .ARM_CYCLES(4), .WDOG_CYCLES(64)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .cmd_start(cmd_start), .cmd_window(cmd_window),
    .cmd_nsamp(cmd_nsamp), .rp_reg_0(rp_reg_0), .rp_reg_1(rp_reg_1),
    .rp_reset(rp_reset), .busy(busy), .done(done), .err_timeout(err_timeout),
    .samples_done(samples_done), .last_count(last_count), .min_count(min_count),
    .max_count(max_count), .sum_count(sum_count)
  );

  initial forever #5 Clk = ~Clk;
  initial begin
    #2;
    forever #4 osc_clk = ~osc_clk;
  end

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          sd;
    logic [30:0] last;
    logic [30:0] mn;
    logic [30:0] mx;
    logic [38:0] sum;
    int          arms;
    int          falls;
    logic [31:0] reg0;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   n_seen = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // ---------------- behavioural rp ----------------
  logic [30:0] model_q[$];
  logic [30:0] model_dflt = '0;
  bit          toggle_en = 1'b0;
  bit          hang_en = 1'b0;
  logic [31:0] model_reg1;
  logic [30:0] settled;
  int          timer;
  logic [1:0]  tog;

  function automatic logic [30:0] model_pop();
    if (model_q.size() > 0) return model_q.pop_front();
    return model_dflt;
  endfunction

  // rp: after go, count a few oscillator edges, then publish {done, count};
  // optionally glitch the low bits for three edges before settling.
  always @(posedge osc_clk or posedge rp_reset) begin
    if (rp_reset) begin
      model_reg1 <= '0;
      timer      <= 0;
      tog        <= '0;
    end else if (rp_reg_0[31] && !hang_en && timer < 5) begin
      timer <= timer + 1;
      if (timer == 3) settled <= model_pop();
      if (timer == 4) begin
        model_reg1 <= {1'b1, toggle_en ? (settled ^ 31'd3) : settled};
        tog        <= toggle_en ? 2'd3 : 2'd0;
      end
    end else if (tog != 2'd0) begin
      tog        <= tog - 2'd1;
      model_reg1 <= {1'b1, settled ^ 31'(tog - 2'd1)};
    end
  end
  assign rp_reg_1 = model_reg1;

  // ---------------- monitor ----------------
  bit          busy_p = 1'b0, done_p = 1'b0, rst_p = 1'b1;
  int          mon_arms = 0, mon_falls = 0;
  logic [31:0] mon_reg0 = '0;
  exp_t        mon_e;

  initial begin
    forever begin
      @(negedge Clk);
      if (Reset_n) begin
        busy_p = 1'b0; done_p = 1'b0; rst_p = 1'b1;
        continue;
      end
      if (busy && !busy_p) begin
        mon_arms = 0; mon_falls = 0;
      end
      if (busy && rp_reset) mon_arms++;
      if (rst_p && !rp_reset) mon_falls++;
      if (rp_reg_0[31]) mon_reg0 = rp_reg_0;
      if (done && !done_p) begin
        if (sb_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_done actual=1 required=0");
        end else begin
          mon_e = sb_q.pop_front();
          chk("samples_done", 64'(samples_done), 64'(mon_e.sd));
          chk("last_count",   64'(last_count),   64'(mon_e.last));
          chk("min_count",    64'(min_count),    64'(mon_e.mn));
          chk("max_count",    64'(max_count),    64'(mon_e.mx));
          chk("sum_count",    64'(sum_count),    64'(mon_e.sum));
          chk("arm_cycles",   64'(mon_arms),     64'(mon_e.arms));
          chk("rp_reset_pulses", 64'(mon_falls), 64'(mon_e.falls));
          chk("rp_reg_0_go",  64'(mon_reg0),     64'(mon_e.reg0));
          chk("err_timeout",  64'(err_timeout),  64'(mon_e.err));
          $display("txn %0d samples=%0d last=0x%0h min=0x%0h max=0x%0h sum=0x%0h arms=%0d pulses=%0d reg0=0x%0h err=%0b",
                   n_seen, samples_done, last_count, min_count, max_count, sum_count,
                   mon_arms, mon_falls, mon_reg0, err_timeout);
        end
        n_seen++;
      end
      busy_p = busy; done_p = done; rst_p = rp_reset;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic start(input logic [30:0] w, input logic [7:0] ns);
    @(negedge Clk);
    cmd_window = w; cmd_nsamp = ns; cmd_start = 1'b1;
    @(negedge Clk);
    cmd_start = 1'b0;
    chk("done_cleared_on_start", 64'(done), 64'd0);
    chk("busy_after_start", 64'(busy), 64'd1);
  endtask

  task automatic wait_seen(input int target, input int budget);
    int n = 0;
    while (n_seen < target && n < budget) begin
      @(negedge Clk);
      n++;
    end
    chk("done_within_budget", 64'(n_seen), 64'(target));
    repeat (2) @(negedge Clk);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset_n = 1'b1;
    repeat (3) @(negedge Clk);
    chk("rst_rp_reset", 64'(rp_reset), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_min_count", 64'(min_count), 64'h7FFF_FFFF);
    chk("rst_samples_done", 64'(samples_done), 64'd0);
    chk("rst_sum_count", 64'(sum_count), 64'd0);
    chk("rst_rp_reg_0", 64'(rp_reg_0), 64'd0);
    Reset_n = 1'b0;
    @(negedge Clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    do_reset();
    chk("idle_done_low", 64'(done), 64'd0);

    // Single sample, window 100.
    model_q.push_back(31'h1234);
    sb_q.push_back('{sd:1, last:31'h1234, mn:31'h1234, mx:31'h1234, sum:39'h1234,
                     arms:4, falls:1, reg0:32'h8000_0064, err:1'b0});
    start(31'd100, 8'd1);
    wait_seen(1, 2000);

    // Three samples; a second cmd_start while busy must be ignored.
    model_q.push_back(31'd10);
    model_q.push_back(31'd30);
    model_q.push_back(31'd20);
    sb_q.push_back('{sd:3, last:31'd20, mn:31'd10, mx:31'd30, sum:39'd60,
                     arms:12, falls:3, reg0:32'h8000_0032, err:1'b0});
    start(31'd50, 8'd3);
    repeat (6) @(negedge Clk);
    cmd_window = 31'd5; cmd_nsamp = 8'd1; cmd_start = 1'b1;
    @(negedge Clk);
    cmd_start = 1'b0;
    wait_seen(2, 2000);

    // nsamp=0 means 256 samples, window 0, full-scale counts.
    model_dflt = 31'h7FFF_FFFF;
    sb_q.push_back('{sd:256, last:31'h7FFF_FFFF, mn:31'h7FFF_FFFF, mx:31'h7FFF_FFFF,
                     sum:39'h7F_FFFF_FF00, arms:1024, falls:256, reg0:32'h8000_0000, err:1'b0});
    start(31'd0, 8'd0);
    wait_seen(3, 20000);
    model_dflt = '0;

    // Low bits glitch after done rises; the settled value must be captured.
    toggle_en = 1'b1;
    model_q.push_back(31'h15A5_A5A0);
    sb_q.push_back('{sd:1, last:31'h15A5_A5A0, mn:31'h15A5_A5A0, mx:31'h15A5_A5A0,
                     sum:39'h15A5_A5A0, arms:4, falls:1, reg0:32'h8000_0007, err:1'b0});
    start(31'd7, 8'd1);
    wait_seen(4, 2000);
    toggle_en = 1'b0;

    // rp never finishes.
    do_reset();
    hang_en = 1'b1;
`ifdef RO_SEQ_WATCHDOG_EN
    sb_q.push_back('{sd:0, last:31'd0, mn:31'h7FFF_FFFF, mx:31'd0, sum:39'd0,
                     arms:4, falls:1, reg0:32'h8000_000C, err:1'b1});
    start(31'd12, 8'd1);
    wait_seen(5, 400);
`else
    start(31'd12, 8'd1);
    repeat (300) @(negedge Clk);
    chk("hang_busy", 64'(busy), 64'd1);
    chk("hang_done", 64'(done), 64'd0);
    chk("hang_err_timeout", 64'(err_timeout), 64'd0);
`endif
    hang_en = 1'b0;
    // Reset mid-run (or after timeout) must abort straight back to IDLE.
    do_reset();

    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
